// File: rtl/calib_pattern_gen.sv
// calib_pattern_gen: streams one calibration frame to the WS281x driver.
// LEDs whose address has the selected bit set are lit ON_COLOR, all others OFF_COLOR.
// After the driver latches the frame and the settle delay expires, display_valid_out is held high.
module calib_pattern_gen #(
    parameter int          NUM_LEDS               = 50,
    parameter int          LED_ADDRESS_WIDTH      = $clog2(NUM_LEDS),
    parameter int          LED_ADDR_BIT_SEL_WIDTH = $clog2(LED_ADDRESS_WIDTH),
    parameter logic [23:0] ON_COLOR               = 24'hFFFFFF,
    parameter logic [23:0] OFF_COLOR              = 24'h000000,
    parameter int          SETTLE_CYCLES          = 1000
) (
    input  logic                              clk_in,
    input  logic                              rst_in,
    input  logic [LED_ADDR_BIT_SEL_WIDTH-1:0] bit_sel_in,
    input  logic                              start_in,
    input  logic                              pixel_ready_in,
    input  logic                              frame_done_in,
    output logic                              pixel_valid_out,
    output logic [LED_ADDRESS_WIDTH-1:0]      pixel_index_out,
    output logic [23:0]                       pixel_color_out,
    output logic                              display_valid_out,
    output logic                              busy_out
);

    localparam int AW    = LED_ADDRESS_WIDTH;
    localparam int SW    = LED_ADDR_BIT_SEL_WIDTH;
    // A zero-cycle settle still needs a 1-bit counter to keep the declaration legal.
    localparam int CNT_W = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        WAIT_FRAME,
        SETTLE,
        VALID
    } state_t;

    state_t             state_q, state_d;
    logic [SW-1:0]      bit_sel_q, bit_sel_d;
    logic [AW-1:0]      index_q, index_d;
    logic [23:0]        color_q, color_d;
    logic               pixel_valid_q, pixel_valid_d;
    logic               display_valid_q, display_valid_d;
    logic               busy_q, busy_d;
    logic [CNT_W-1:0]   settle_cnt_q, settle_cnt_d;
    logic               last_pixel;

    // Colour of an LED; a select beyond the address width never matches a set bit.
    function automatic logic [23:0] color_for(input logic [AW-1:0] idx, input logic [SW-1:0] sel);
        logic [AW-1:0] shifted;
        if (32'(sel) >= 32'(AW)) begin
            return OFF_COLOR;
        end
        shifted = idx >> sel;
        return shifted[0] ? ON_COLOR : OFF_COLOR;
    endfunction

    // Compare one bit wider so a power-of-two NUM_LEDS still fits.
    assign last_pixel = ({1'b0, index_q} == (AW+1)'(NUM_LEDS - 1));

    // Next-state and next-output computation for the frame FSM.
    always_comb begin
        state_d         = state_q;
        bit_sel_d       = bit_sel_q;
        index_d         = index_q;
        color_d         = color_q;
        pixel_valid_d   = pixel_valid_q;
        display_valid_d = display_valid_q;
        busy_d          = busy_q;
        settle_cnt_d    = settle_cnt_q;

        unique case (state_q)
            IDLE, VALID: begin
                if (start_in) begin
                    state_d         = SEND;
                    bit_sel_d       = bit_sel_in;
                    index_d         = '0;
                    color_d         = color_for('0, bit_sel_in);
                    pixel_valid_d   = 1'b1;
                    display_valid_d = 1'b0;
                    busy_d          = 1'b1;
                end
            end
            SEND: begin
                if (pixel_valid_q && pixel_ready_in) begin
                    if (last_pixel) begin
                        state_d       = WAIT_FRAME;
                        pixel_valid_d = 1'b0;
                    end else begin
                        index_d = index_q + 1'b1;
                        color_d = color_for(index_q + 1'b1, bit_sel_q);
                    end
                end
            end
            WAIT_FRAME: begin
                if (frame_done_in) begin
                    if (SETTLE_CYCLES == 0) begin
                        state_d         = VALID;
                        display_valid_d = 1'b1;
                        busy_d          = 1'b0;
                    end else begin
                        state_d      = SETTLE;
                        settle_cnt_d = CNT_W'(SETTLE_CYCLES);
                    end
                end
            end
            SETTLE: begin
                if (settle_cnt_q == CNT_W'(1)) begin
                    state_d         = VALID;
                    settle_cnt_d    = '0;
                    display_valid_d = 1'b1;
                    busy_d          = 1'b0;
                end else begin
                    settle_cnt_d = settle_cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs with synchronous reset.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q         <= IDLE;
            bit_sel_q       <= '0;
            index_q         <= '0;
            color_q         <= OFF_COLOR;
            pixel_valid_q   <= 1'b0;
            display_valid_q <= 1'b0;
            busy_q          <= 1'b0;
            settle_cnt_q    <= '0;
        end else begin
            state_q         <= state_d;
            bit_sel_q       <= bit_sel_d;
            index_q         <= index_d;
            color_q         <= color_d;
            pixel_valid_q   <= pixel_valid_d;
            display_valid_q <= display_valid_d;
            busy_q          <= busy_d;
            settle_cnt_q    <= settle_cnt_d;
        end
    end

    assign pixel_valid_out   = pixel_valid_q;
    assign pixel_index_out   = index_q;
    assign pixel_color_out   = color_q;
    assign display_valid_out = display_valid_q;
    assign busy_out          = busy_q;

endmodule

// File: tb/tb_calib_pattern_gen.sv
// Self-checking bench for calib_pattern_gen: randomized backpressure frames
// compared against an arithmetic model of the colour rule and settle timing.
module tb_calib_pattern_gen;

    localparam int N   = 50;
    localparam int AW  = 6;
    localparam int SW  = 3;
    localparam int SET = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [SW-1:0] bit_sel = '0;
    logic          start = 1'b0;
    logic          ready = 1'b1;
    logic          done = 1'b0;

    logic          pv, disp, busy;
    logic [AW-1:0] pidx;
    logic [23:0]   pcol;
    logic          pv0, disp0, busy0;
    logic [AW-1:0] pidx0;
    logic [23:0]   pcol0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    calib_pattern_gen #(.NUM_LEDS(N), .SETTLE_CYCLES(SET)) dut (
        .clk_in(clk), .rst_in(rst), .bit_sel_in(bit_sel), .start_in(start),
        .pixel_ready_in(ready), .frame_done_in(done),
        .pixel_valid_out(pv), .pixel_index_out(pidx), .pixel_color_out(pcol),
        .display_valid_out(disp), .busy_out(busy)
    );

    calib_pattern_gen #(.NUM_LEDS(N), .SETTLE_CYCLES(0)) dut0 (
        .clk_in(clk), .rst_in(rst), .bit_sel_in(bit_sel), .start_in(start),
        .pixel_ready_in(ready), .frame_done_in(done),
        .pixel_valid_out(pv0), .pixel_index_out(pidx0), .pixel_color_out(pcol0),
        .display_valid_out(disp0), .busy_out(busy0)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference colour: LED lit when bit 'sel' of its address is one.
    function automatic int exp_color(input int idx, input int sel);
        if (sel < AW && ((idx / (1 << sel)) % 2) == 1) return 32'hFFFFFF;
        return 0;
    endfunction

    // One frame: pulse start, then follow every transfer against the model.
    task automatic frame(input int sel, input bit rnd, input bit inject);
        int idx = 0;
        int cyc = 0;
        @(negedge clk);
        bit_sel = SW'(sel);
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("disp_drop_on_start", disp, 0);
        while (idx < N && cyc < 1000) begin
            check("pix_valid", pv, 1);
            check("pix_index", pidx, idx);
            check("pix_color", pcol, exp_color(idx, sel));
            check("busy_send", busy, 1);
            check("disp_send", disp, 0);
            ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            start = inject && idx == 10;
            done  = inject && idx == 12;
            @(negedge clk);
            start = 1'b0;
            done  = 1'b0;
            if (ready) idx++;
            cyc++;
        end
        ready = 1'b1;
        check("frame_timeout", idx, N);
        check("valid_after_last", pv, 0);
        check("busy_wait", busy, 1);
    endtask

    // Pulse frame_done and check both settle latencies.
    task automatic settle();
        @(negedge clk);
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        check("disp0_f_plus_1", disp0, 1);
        for (int i = 1; i <= SET; i++) begin
            if (i < SET) begin
                check("disp_settling", disp, 0);
                @(negedge clk);
            end else begin
                check("disp_settling", disp, 0);
                @(negedge clk);
                check("disp_settled", disp, 1);
                check("busy_valid", busy, 0);
            end
        end
    endtask

    task automatic reset_outputs(input string tag);
        check({tag, "_valid"}, pv, 0);
        check({tag, "_index"}, pidx, 0);
        check({tag, "_color"}, pcol, 0);
        check({tag, "_disp"}, disp, 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        reset_outputs("reset");
        rst = 1'b0;

        // Basic frame, ready tied high.
        frame(0, 1'b0, 1'b0);
        repeat (3) begin
            @(negedge clk);
            check("disp_before_done", disp, 0);
        end
        settle();

        // Backpressure with bit 3.
        frame(3, 1'b1, 1'b0);
        settle();

        // Out-of-range select, started from VALID.
        frame(6, 1'b0, 1'b0);
        settle();

        // Held VALID level.
        repeat (5) @(negedge clk);
        check("disp_held", disp, 1);

        // Stray start/done during SEND must be ignored.
        frame(5, 1'b1, 1'b1);
        repeat (10) begin
            @(negedge clk);
            check("disp_no_early", disp, 0);
            check("busy_waiting", busy, 1);
        end
        settle();

        // Reset mid-SETTLE with simultaneous start.
        frame(2, 1'b1, 1'b0);
        @(negedge clk);
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        reset_outputs("midreset");
        repeat (SET + 2) @(negedge clk);
        check("disp_after_reset", disp, 0);
        check("busy_after_reset", busy, 0);
        frame(1, 1'b1, 1'b0);
        settle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/calib_pattern_gen.md
Name: calib_pattern_gen

Overview:
- Sits directly downstream of the calibration sequencer's bit-select outputs and upstream of the WS281x strip driver.
- On each start pulse, streams one full frame to the driver. Every LED whose address has the selected bit set is lit ON_COLOR; every other LED is OFF_COLOR.
- After the driver reports the frame latched and a settle delay expires, holds display_valid_out high. The sequencer uses this level to start the camera calibration step.

Parameters:
- NUM_LEDS, 50, number of LEDs on the strip.
- LED_ADDRESS_WIDTH, $clog2(NUM_LEDS), width of an LED index.
- LED_ADDR_BIT_SEL_WIDTH, $clog2(LED_ADDRESS_WIDTH), width of the bit-select.
- ON_COLOR, 24'hFFFFFF, GRB value for an LED whose selected address bit is 1.
- OFF_COLOR, 24'h000000, GRB value for an LED whose selected address bit is 0.
- SETTLE_CYCLES, 1000, cycles to wait after frame_done_in before asserting valid; 0 is legal.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  reset.
- bit_sel_in  input  LED_ADDR_BIT_SEL_WIDTH  address bit to display; sampled on start.
- start_in  input  1  one-cycle pulse requesting a new frame.
- pixel_ready_in  input  1  driver can accept a pixel.
- frame_done_in  input  1  one-cycle pulse from the driver when the strip has latched the frame.
- pixel_valid_out  output  1  pixel_color_out and pixel_index_out are valid.
- pixel_index_out  output  LED_ADDRESS_WIDTH  LED index of the current pixel.
- pixel_color_out  output  24  GRB colour of the current pixel.
- display_valid_out  output  1  level: requested pattern is physically displayed and settled.
- busy_out  output  1  high in any state other than IDLE and VALID.

Behaviour:
- Interface: one clock, clk_in. Reset rst_in is synchronous and active-high.
- Reset, including mid-operation: state=IDLE; pixel_valid_out=0; pixel_index_out=0; pixel_color_out=OFF_COLOR; display_valid_out=0; busy_out=0; settle counter=0; the in-flight frame is abandoned.
- States and transitions:
  - IDLE: on start_in, latch bit_sel_in into bit_sel_q, set index=0, go to SEND.
  - SEND:
    - Drive pixel_valid_out=1 and index/colour, all registered.
    - A transfer occurs when pixel_valid_out && pixel_ready_in.
    - On a transfer with index<NUM_LEDS-1: index increments; the next pixel is presented the following cycle with valid still high, so back-to-back transfers sustain one pixel per cycle.
    - On a transfer with index==NUM_LEDS-1: go to WAIT_FRAME; pixel_valid_out=0 the next cycle. Index does not wrap.
    - Valid, index and colour are held stable while ready is low.
  - WAIT_FRAME: on frame_done_in, load the settle counter and go to SETTLE. If SETTLE_CYCLES==0, go straight to VALID.
  - SETTLE: count SETTLE_CYCLES cycles, then go to VALID.
  - VALID: display_valid_out=1, held until start_in or reset. On start_in: display_valid_out=0 the next cycle, latch the new bit_sel_in, go to SEND with index=0.
- Colour rule: pixel_color_out = (index >> bit_sel_q) & 1 ? ON_COLOR : OFF_COLOR. If bit_sel_q >= LED_ADDRESS_WIDTH, all pixels are OFF_COLOR.
- Latency: start_in at cycle t gives pixel_valid_out=1, index 0 at t+1. frame_done_in at cycle f gives display_valid_out=1 at f+SETTLE_CYCLES+1.
- Ignored events:
  - start_in in SEND, WAIT_FRAME or SETTLE: ignored, with no queuing.
  - frame_done_in outside WAIT_FRAME: ignored. This covers a stale done from a previous frame arriving during SEND.
  - Simultaneous start_in and rst_in: reset wins.
- Width rules: the settle counter is $clog2(SETTLE_CYCLES+1) bits wide. The index comparison is done at LED_ADDRESS_WIDTH+1 bits so NUM_LEDS equal to a power of two is handled.

Test Plan:
- Basic frame: reset; bit_sel_in=0, start_in pulse; ready tied high → 50 consecutive transfers, indices 0..49; colour ON for odd indices, OFF for even; then pixel_valid_out=0. Pulse frame_done_in with SETTLE_CYCLES=4 → display_valid_out=1 exactly 5 cycles after the done pulse.
- Backpressure: bit_sel_in=3; toggle pixel_ready_in pseudo-randomly → index, colour and valid are stable while stalled; each index is transferred exactly once; indices 8..15, 24..31 and 40..47 are ON_COLOR.
- Out-of-range select and restart: with NUM_LEDS=50 (LED_ADDRESS_WIDTH=6), bit_sel_in=6 → all 50 pixels OFF_COLOR. Then start_in while in VALID → display_valid_out drops the next cycle and index 0 is re-presented.
- Ignored events: start_in and frame_done_in pulsed during SEND → no restart, no early valid; state still waits in WAIT_FRAME for a real done.
- Reset mid-SETTLE: assert rst_in → every output returns to its reset value the next cycle; a subsequent start_in runs a full correct frame.
- SETTLE_CYCLES=0: frame_done_in at cycle f → display_valid_out=1 at f+1.
